// File: rtl/dmem_mmio_unit.sv
// Data-memory unit behind the MEM stage: word RAM plus an MMIO window holding a
// 4-entry transmit FIFO (valid/ready drained) and sticky status flags.
module dmem_mmio_unit #(
  parameter int unsigned DEPTH     = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] proc2Dmem_addr,
  input  logic [1:0]  proc2Dmem_command,
  input  logic [31:0] proc2mem_data,
  output logic [31:0] mem2proc_data,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        overflow,
  output logic        bus_error
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam logic [29:0] TX_WADDR     = MMIO_BASE[31:2];
  localparam logic [29:0] STATUS_WADDR = MMIO_BASE[31:2] + 30'd1;
  localparam logic [29:0] CLR_WADDR    = MMIO_BASE[31:2] + 30'd2;

  // Handshake: the sink takes tx_data in any cycle where tx_valid & tx_ready
  // are both high at the clock edge; while tx_valid & !tx_ready, tx_data and
  // tx_valid hold steady because only a pop moves the read pointer.

  logic [31:0] mem_q [DEPTH];

  logic [31:0] fifo_q [4];
  logic [1:0]  rd_ptr_q, wr_ptr_q;
  logic [2:0]  count_q, count_d;
  logic        overflow_q, overflow_d;
  logic        bus_error_q, bus_error_d;

  logic          is_load, is_store, is_access;
  logic          ram_hit, tx_hit, status_hit, clr_hit, unmapped;
  logic [AW-1:0] word_idx;
  logic          full, empty, push, pop, drop;
  logic [31:0]   status_word;

  assign is_load   = (proc2Dmem_command == BUS_LOAD);
  assign is_store  = (proc2Dmem_command == BUS_STORE);
  assign is_access = is_load | is_store;

  // DEPTH is a power of two, so "addr < DEPTH*4" is "upper bits all zero".
  assign ram_hit    = (proc2Dmem_addr[31:AW+2] == '0);
  assign tx_hit     = (proc2Dmem_addr[31:2] == TX_WADDR);
  assign status_hit = (proc2Dmem_addr[31:2] == STATUS_WADDR);
  assign clr_hit    = (proc2Dmem_addr[31:2] == CLR_WADDR);
  assign unmapped   = !(ram_hit | tx_hit | status_hit | clr_hit);
  assign word_idx   = proc2Dmem_addr[AW+1:2];

  assign full        = (count_q == 3'd4);
  assign empty       = (count_q == 3'd0);
  assign status_word = {25'b0, bus_error_q, overflow_q, full, empty, count_q};

  assign tx_valid  = !empty;
  assign tx_data   = fifo_q[rd_ptr_q];
  assign overflow  = overflow_q;
  assign bus_error = bus_error_q;

  // A pop frees a slot in the same edge, so a full FIFO still accepts a push.
  always_comb begin
    pop  = tx_valid & tx_ready;
    push = is_store & tx_hit & (!full | pop);
    drop = is_store & tx_hit & full & !pop;
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    overflow_d  = overflow_q | drop;
    bus_error_d = bus_error_q | (is_access & unmapped);
    if (is_store & clr_hit) begin
      overflow_d  = 1'b0;
      bus_error_d = 1'b0;
    end
  end

  always_comb begin
    mem2proc_data = 32'b0;
    if (is_load) begin
      if (ram_hit) begin
        mem2proc_data = mem_q[word_idx];
      end else if (status_hit) begin
        mem2proc_data = status_word;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        fifo_q[i] <= 32'b0;
      end
      rd_ptr_q    <= 2'b0;
      wr_ptr_q    <= 2'b0;
      count_q     <= 3'b0;
      overflow_q  <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= proc2mem_data;
        wr_ptr_q         <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      bus_error_q <= bus_error_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (is_store & ram_hit) begin
      mem_q[word_idx] <= proc2mem_data;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_unit.sv
// Bench for dmem_mmio_unit: directed plan steps followed by random bus traffic,
// each cycle checked against a queue/array model of RAM, FIFO and flags.
module tb_dmem_mmio_unit;

  localparam int unsigned DEPTH     = 1024;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] TX_A      = MMIO_BASE;
  localparam logic [31:0] STATUS_A  = MMIO_BASE + 32'd4;
  localparam logic [31:0] CLR_A     = MMIO_BASE + 32'd8;

  localparam logic [1:0] BUS_NONE  = 2'h0;
  localparam logic [1:0] BUS_LOAD  = 2'h1;
  localparam logic [1:0] BUS_STORE = 2'h2;

  localparam int R_RAM = 0, R_TX = 1, R_STATUS = 2, R_CLR = 3, R_UNMAPPED = 4;

  logic        clk;
  logic        rst;
  logic [31:0] addr_s;
  logic [1:0]  cmd_s;
  logic [31:0] wdata_s;
  logic [31:0] mem2proc_data;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        overflow;
  logic        bus_error;

  dmem_mmio_unit #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE)) dut (
    .clk              (clk),
    .rst              (rst),
    .proc2Dmem_addr   (addr_s),
    .proc2Dmem_command(cmd_s),
    .proc2mem_data    (wdata_s),
    .mem2proc_data    (mem2proc_data),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .overflow         (overflow),
    .bus_error        (bus_error)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard and reference model
  logic [31:0] exp_q[$];
  logic [31:0] ram_m [int unsigned];
  bit          ovf_m;
  bit          be_m;
  int          checks;
  int          errors;

  logic [31:0] last_ld;
  logic [31:0] last_txd;
  logic        last_txv;
  logic        last_ovf;
  logic        last_be;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    logic [31:0] w;
    w = a & ~32'd3;
    if (a < DEPTH * 4) return R_RAM;
    if (w == TX_A)     return R_TX;
    if (w == STATUS_A) return R_STATUS;
    if (w == CLR_A)    return R_CLR;
    return R_UNMAPPED;
  endfunction

  function automatic logic [31:0] model_status();
    int sz;
    sz = exp_q.size();
    return {25'b0, be_m, ovf_m, sz == 4, sz == 0, 3'(sz)};
  endfunction

  // Returns 1 when the load value is defined (never-written RAM is not).
  function automatic bit model_load(input logic [1:0] cmd, input logic [31:0] a,
                                    output logic [31:0] v);
    v = 32'b0;
    if (cmd == BUS_STORE) return 1'b0;
    if (cmd != BUS_LOAD) return 1'b1;
    case (region(a))
      R_RAM: begin
        if (!ram_m.exists(a >> 2)) return 1'b0;
        v = ram_m[a >> 2];
      end
      R_STATUS: v = model_status();
      default:  v = 32'b0;
    endcase
    return 1'b1;
  endfunction

  // Driver: one bus cycle, checked mid-cycle, model advanced at the edge.
  task automatic step(input logic [1:0] cmd, input logic [31:0] a,
                      input logic [31:0] d, input logic ready);
    logic [31:0] exp_ld;
    int          r;
    @(negedge clk);
    cmd_s    = cmd;
    addr_s   = a;
    wdata_s  = d;
    tx_ready = ready;
    #1;
    last_ld  = mem2proc_data;
    last_txd = tx_data;
    last_txv = tx_valid;
    last_ovf = overflow;
    last_be  = bus_error;
    if (model_load(cmd, a, exp_ld)) check("load", mem2proc_data, exp_ld);
    check("tx_valid", tx_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check("tx_data", tx_data, exp_q[0]);
    check("overflow", overflow, ovf_m);
    check("bus_error", bus_error, be_m);
    @(posedge clk);
    if (exp_q.size() != 0 && ready) void'(exp_q.pop_front());
    r = region(a);
    if (cmd == BUS_STORE) begin
      case (r)
        R_RAM: ram_m[a >> 2] = d;
        R_TX: begin
          if (exp_q.size() < 4) exp_q.push_back(d);
          else ovf_m = 1'b1;
        end
        R_CLR: begin
          ovf_m = 1'b0;
          be_m  = 1'b0;
        end
        R_UNMAPPED: be_m = 1'b1;
        default: ;
      endcase
    end else if (cmd == BUS_LOAD && r == R_UNMAPPED) begin
      be_m = 1'b1;
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0, 1:    return 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
      2:       return TX_A + 32'($urandom_range(0, 3));
      3:       return STATUS_A;
      4:       return CLR_A;
      5:       return 32'h8000_0000 | 32'($urandom_range(0, 255));
      default: return (($urandom_range(0, 1) == 0) ? DEPTH * 4 : MMIO_BASE + 32'd12);
    endcase
  endfunction

  initial begin
    checks   = 0;
    errors   = 0;
    ovf_m    = 1'b0;
    be_m     = 1'b0;
    rst      = 1'b1;
    cmd_s    = BUS_NONE;
    addr_s   = 32'b0;
    wdata_s  = 32'b0;
    tx_ready = 1'b0;

    // Reset state
    #1;
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_data", tx_data, 32'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_bus_error", bus_error, 1'b0);
    check("rst_none_load", mem2proc_data, 32'b0);
    @(negedge clk);
    rst = 1'b0;

    // RAM store/load
    step(BUS_STORE, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(BUS_STORE, 32'h14, 32'h0000_1234, 1'b0);
    step(BUS_LOAD, 32'h10, 32'h0, 1'b0);
    check("ram_10", last_ld, 32'hDEAD_BEEF);
    step(BUS_LOAD, 32'h13, 32'h0, 1'b0);
    check("ram_13", last_ld, 32'hDEAD_BEEF);
    step(BUS_LOAD, 32'h14, 32'h0, 1'b0);
    check("ram_14", last_ld, 32'h0000_1234);
    step(BUS_STORE, 32'h10, 32'h0BAD_F00D, 1'b0);
    step(BUS_LOAD, 32'h10, 32'h0, 1'b0);
    check("ram_10_new", last_ld, 32'h0BAD_F00D);

    // TX fill then drain
    for (int i = 1; i <= 4; i++) step(BUS_STORE, TX_A, 32'(i), 1'b0);
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b0);
    check("status_full", last_ld, 32'h14);
    for (int i = 1; i <= 4; i++) begin
      step(BUS_NONE, 32'h0, 32'h0, 1'b1);
      check("drain_valid", last_txv, 1'b1);
      check("drain_data", last_txd, 32'(i));
    end
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b1);
    check("drain_empty_valid", last_txv, 1'b0);
    check("status_empty", last_ld, 32'h08);

    // Overflow and push-while-full-with-pop
    for (int i = 1; i <= 4; i++) step(BUS_STORE, TX_A, 32'(i), 1'b0);
    step(BUS_STORE, TX_A, 32'd5, 1'b0);
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b0);
    check("ovf_flag", last_ovf, 1'b1);
    check("status_ovf", last_ld, 32'h34);
    step(BUS_STORE, TX_A, 32'd6, 1'b1);
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b0);
    check("status_full_after_pushpop", last_ld, 32'h34);
    begin
      logic [31:0] order [4];
      order[0] = 32'd2; order[1] = 32'd3; order[2] = 32'd4; order[3] = 32'd6;
      for (int i = 0; i < 4; i++) begin
        step(BUS_NONE, 32'h0, 32'h0, 1'b1);
        check("ovf_drain_order", last_txd, order[i]);
      end
    end

    // Bus error and CLR
    step(BUS_LOAD, 32'h8000_0000, 32'h0, 1'b0);
    check("unmapped_load", last_ld, 32'b0);
    step(BUS_NONE, 32'h0, 32'h0, 1'b0);
    check("bus_error_set", last_be, 1'b1);
    step(BUS_STORE, CLR_A, $urandom, 1'b0);
    step(BUS_NONE, 32'h0, 32'h0, 1'b0);
    check("clr_overflow", last_ovf, 1'b0);
    check("clr_bus_error", last_be, 1'b0);

    // Wrap: one push and one pop per cycle
    for (int i = 0; i < 10; i++) begin
      step(BUS_STORE, TX_A, 32'(100 + i), 1'b1);
      if (i > 0) check("wrap_head", last_txd, 32'(99 + i));
    end
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b1);
    check("wrap_count1", last_ld, 32'h01);
    check("wrap_last", last_txd, 32'd109);
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b1);
    check("wrap_empty", last_ld, 32'h08);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(2'($urandom_range(0, 3)), rand_addr(), $urandom, 1'($urandom_range(0, 1)));
    end

    // Reset mid-operation with 3 entries queued
    for (int i = 0; i < 5; i++) step(BUS_NONE, 32'h0, 32'h0, 1'b1);
    step(BUS_STORE, 32'h8000_0004, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(BUS_STORE, TX_A, $urandom, 1'b0);
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b0);
    check("pre_rst_count", last_ld & 32'h7, 32'h3);
    @(negedge clk);
    cmd_s  = BUS_LOAD;
    addr_s = STATUS_A;
    #2;
    rst = 1'b1;
    #1;
    check("midrst_tx_valid", tx_valid, 1'b0);
    check("midrst_tx_data", tx_data, 32'b0);
    check("midrst_overflow", overflow, 1'b0);
    check("midrst_bus_error", bus_error, 1'b0);
    check("midrst_status", mem2proc_data, 32'h08);
    exp_q.delete();
    ovf_m = 1'b0;
    be_m  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(BUS_LOAD, STATUS_A, 32'h0, 1'b0);
    check("post_rst_status", last_ld, 32'h08);
    for (int i = 0; i < 16; i++) step(BUS_LOAD, 32'(i * 4), 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
